// File: rtl/fp_align_pkg.sv
// Shared widths, slice helper and stage bundle for the alignment shifter.
// Sticky accumulation is enabled by defining FP_RSHIFT_STICKY_EN.
package fp_align_pkg;

   localparam int IN_W_D    = 48;
   localparam int OUT_W_D   = 23;
   localparam int LSB_POS_D = 23;
   localparam int SHAMT_W_D = 8;
   localparam int STAGES_D  = 2;
   localparam int TAG_W_D   = 4;

   function automatic int slice_w(int shamt_w, int stages);
      return (shamt_w + stages - 1) / stages;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [IN_W_D-1:0]    data;
      logic [SHAMT_W_D-1:0] shamt;
      logic                 sticky;
      logic [TAG_W_D-1:0]   tag;
   } stage_t;

endpackage

// File: rtl/fp_rshift_stage.sv
// One registered shift stage: consumes its slice of the shift amount.
// Bits shifted out feed the running sticky only with FP_RSHIFT_STICKY_EN.
module fp_rshift_stage
   import fp_align_pkg::*;
#(
   parameter int  IDX     = 0,
   parameter int  B       = 4,
   parameter int  IN_W    = IN_W_D,
   parameter int  SHAMT_W = SHAMT_W_D,
   parameter type st_t    = stage_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  st_t  up,
   output st_t  dn
);

   // Slice mask, truncated to SHAMT_W for the top stage.
   localparam logic [SHAMT_W-1:0] SLICE =
      SHAMT_W'(((64'd1 << B) - 64'd1) << (IDX * B));

   logic [SHAMT_W-1:0] amt;
   logic [IN_W-1:0]    shifted;
   logic               sticky_nxt;

   assign amt     = up.shamt & SLICE;
   assign shifted = up.data >> amt;

`ifdef FP_RSHIFT_STICKY_EN
   logic lost;
   assign lost       = |(up.data & ~({IN_W{1'b1}} << amt));
   assign sticky_nxt = up.sticky | lost;
`else
   logic unused_sticky;
   assign unused_sticky = up.sticky;
   assign sticky_nxt    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn <= '0;
      end else if (load) begin
         dn.valid <= up.valid;
         if (up.valid) begin
            dn.data   <= shifted;
            dn.shamt  <= up.shamt & ~SLICE;
            dn.sticky <= sticky_nxt;
            dn.tag    <= up.tag;
         end
      end
   end

endmodule

// File: rtl/fp_align_rshift_pipe.sv
// Pipelined right shifter with guard/sticky extraction and valid/ready flow.
// Define FP_RSHIFT_STICKY_EN to build the sticky logic; otherwise sticky is 0.
module fp_align_rshift_pipe
   import fp_align_pkg::*;
#(
   parameter int IN_W    = IN_W_D,
   parameter int OUT_W   = OUT_W_D,
   parameter int LSB_POS = LSB_POS_D,
   parameter int SHAMT_W = SHAMT_W_D,
   parameter int STAGES  = STAGES_D,
   parameter int TAG_W   = TAG_W_D
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_guard,
   output logic               out_sticky,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int B = slice_w(SHAMT_W, STAGES);

   typedef struct packed {
      logic               valid;
      logic [IN_W-1:0]    data;
      logic [SHAMT_W-1:0] shamt;
      logic               sticky;
      logic [TAG_W-1:0]   tag;
   } pipe_t;

   pipe_t       pipe [STAGES+1];
   pipe_t       last;
   logic [STAGES:0] go;
   logic        low;

   assign pipe[0] = '{valid: in_valid, data: in_data,
                      shamt: in_shamt, sticky: 1'b0, tag: in_tag};

   // go[k]: stage k loads; go[STAGES] is the consumer's accept.
   always_comb begin
      go = '0;
      go[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         go[k] = !pipe[k+1].valid || go[k+1];
      end
   end

   assign in_ready = go[0];

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      fp_rshift_stage #(
         .IDX     (g),
         .B       (B),
         .IN_W    (IN_W),
         .SHAMT_W (SHAMT_W),
         .st_t    (pipe_t)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (go[g]),
         .up    (pipe[g]),
         .dn    (pipe[g+1])
      );
   end

   assign last      = pipe[STAGES];
   assign out_valid = last.valid;
   assign out_data  = last.data[LSB_POS +: OUT_W];
   assign out_guard = last.data[LSB_POS-1];
   assign out_tag   = last.tag;

   if (LSB_POS > 1) begin : g_low
      assign low = |last.data[LSB_POS-2:0];
   end else begin : g_nolow
      assign low = 1'b0;
   end

`ifdef FP_RSHIFT_STICKY_EN
   assign out_sticky = last.sticky | low;
`else
   assign out_sticky = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{last.shamt, last.data, last.sticky, low};

endmodule

// File: tb/tb_fp_align_rshift_pipe.sv
// Scoreboard bench: randomized beats checked against a bit-level model.
// Expected sticky follows FP_RSHIFT_STICKY_EN as built.
module tb_fp_align_rshift_pipe;

   localparam int IN_W  = 48;
   localparam int OUT_W = 23;
   localparam int LSB   = 23;
   localparam int SW    = 8;
   localparam int ST    = 2;
   localparam int TW    = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [IN_W-1:0] in_data = '0;
   logic [SW-1:0]   in_shamt = '0;
   logic [TW-1:0]   in_tag = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic            out_guard;
   logic            out_sticky;
   logic [TW-1:0]   out_tag;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic             g;
      logic             s;
      logic [TW-1:0]    tag;
      int               t;
      bit               lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ncyc  = 0;
   int   n_acc = 0;
   int   n_out = 0;
   bit   lat_chk = 1'b0;
   bit   done = 1'b0;

   fp_align_rshift_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_shamt   (in_shamt),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_guard  (out_guard),
      .out_sticky (out_sticky),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   // Reference: shift the whole word, then collect every set input bit
   // that falls strictly below the guard slot after shifting.
   function automatic exp_t model(logic [IN_W-1:0] d, logic [SW-1:0] s,
                                  logic [TW-1:0] t);
      exp_t e;
      logic [IN_W-1:0] sh;
      sh = (int'(s) >= IN_W) ? '0 : d >> s;
      e.data = sh[LSB +: OUT_W];
      e.g    = sh[LSB-1];
      e.s    = 1'b0;
`ifdef FP_RSHIFT_STICKY_EN
      for (int i = 0; i < IN_W; i++)
         if (d[i] && i < int'(s) + LSB - 1) e.s = 1'b1;
`endif
      e.tag = t;
      e.t   = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Monitor: inputs and outputs sampled mid-cycle, away from the edge.
   always @(negedge clk) begin : mon
      exp_t e;
      ncyc++;
      if (rst_n) begin
         if (in_valid && in_ready) begin
            e = model(in_data, in_shamt, in_tag);
            e.t   = ncyc;
            e.lat = lat_chk;
            exp_q.push_back(e);
            n_acc++;
         end
         if (out_valid && out_ready) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_beat: got tag %0h, required none",
                        out_tag);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_guard, out_sticky, out_tag} !==
                   {e.data, e.g, e.s, e.tag}) begin
                  n_bad++;
                  $display("FAIL beat_tag%0h: got d=%h g=%b s=%b t=%h, required d=%h g=%b s=%b t=%h",
                           e.tag, out_data, out_guard, out_sticky, out_tag,
                           e.data, e.g, e.s, e.tag);
               end
               if (e.lat) begin
                  n_cmp++;
                  if (ncyc - e.t != ST) begin
                     n_bad++;
                     $display("FAIL latency_tag%0h: got %0d, required %0d",
                              e.tag, ncyc - e.t, ST);
                  end
               end
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(logic [IN_W-1:0] d, logic [SW-1:0] s,
                       logic [TW-1:0] t, bit lat);
      int w = 0;
      bit ok = 1'b0;
      in_data  = d;
      in_shamt = s;
      in_tag   = t;
      lat_chk  = lat;
      in_valid = 1'b1;
      while (!ok && w < 1000) begin
         @(negedge clk);
         ok = in_ready && rst_n;
         @(posedge clk);
         #1;
         w++;
      end
      in_valid = 1'b0;
      lat_chk  = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: tag %0h not accepted, required accept", t);
      end
   endtask

   task automatic send_rand(logic [TW-1:0] t);
      logic [63:0]     r;
      logic [IN_W-1:0] d;
      logic [SW-1:0]   s;
      r = {$urandom, $urandom};
      d = r[IN_W-1:0];
      if ($urandom_range(0, 2) == 0) d = IN_W'(1) << $urandom_range(0, IN_W - 1);
      if ($urandom_range(0, 3) == 0) s = SW'($urandom);
      else s = SW'($urandom_range(0, 50));
      send(d, s, t, 1'b0);
   endtask

   initial begin : wdog
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int b_acc;
      int b_out;
      int w;
      // Beats offered during reset must vanish.
      in_valid = 1'b1;
      in_data  = 48'h1234_5678_9ABC;
      in_tag   = 4'hF;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_guard", 64'(out_guard), 64'd0);
      chk("rst_out_sticky", 64'(out_sticky), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      send(48'h8000_0000_0000, 8'd2, 4'h1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      send(48'h0000_0080_0001, 8'd0, 4'h2, 1'b1);
      send(48'hFFFF_FFFF_FFFF, 8'd200, 4'h3, 1'b1);
      send(48'h0000_0040_0000, 8'd0, 4'h4, 1'b1);
      send(48'h8000_0000_0001, 8'd47, 4'h5, 1'b1);
      send(48'h8000_0000_0001, 8'd48, 4'h6, 1'b1);
      send(48'hFFFF_FFFF_FFFF, 8'd255, 4'h7, 1'b1);
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: only STAGES beats fit, then release a burst.
      out_ready = 1'b0;
      b_acc = n_acc;
      fork
         for (int t = 1; t <= 4; t++) send_rand(TW'(t));
      join_none
      repeat (6) @(negedge clk);
      #1;
      chk("bp_accepted", 64'(n_acc - b_acc), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      b_out = n_out;
      repeat (4) @(negedge clk);
      #1;
      chk("bp_burst", 64'(n_out - b_out), 64'd4);
      wait fork;
      repeat (3) @(posedge clk);
      #1;

      // Reset with two beats in flight.
      out_ready = 1'b0;
      send(48'hABCD_EF01_2345, 8'd3, 4'h5, 1'b0);
      send(48'h0123_4567_89AB, 8'd9, 4'h6, 1'b0);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      chk("rst_async_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_tag   = 4'h7;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_stale", 64'(out_valid), 64'd0);
      send(48'h0000_0080_0001, 8'd1, 4'h8, 1'b1);
      repeat (4) @(posedge clk);
      #1;

      // Random traffic with random backpressure.
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send_rand(TW'(i));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      w = 0;
      while (exp_q.size() > 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
